dmem_ctrl: RTL and testbench

- Data-memory responder on the far side of the MemRead/MemWrite control lines that the main decoder drives.
- Accepts one load or store per request. Performs it against an internal word-organised byte-enable RAM after a programmable number of wait states.
- Returns sign- or zero-extended load data, or commits byte/half/word stores.
- Holds the single-cycle datapath with Stall until the access completes.

---
 rtl/dmem_pkg.sv | 82 ++++++++
 rtl/dmem_array.sv | 28 ++
 rtl/dmem_ctrl.sv | 118 +++++++++++
 tb/tb_dmem_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [31:0] load_ext(
        input logic [31:0] word,
        input logic [2:0]  f3,
        input logic [1:0]  lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'd0, b};
            F3_HU:   r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] byte_en(
        input logic [2:0] f3,
        input logic [1:0] lane
    );
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << lane;
            F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_align(
        input logic [2:0]  f3,
        input logic [31:0] data
    );
        logic [31:0] r;
        case (f3)
            F3_B:    r = {4{data[7:0]}};
            F3_H:    r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic req_err(
        input logic       rd,
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] lane
    );
        logic bad;
        bad = rd & wr;
        case (f3)
            F3_B:         bad = bad;
            F3_BU:        bad = bad | wr;
            F3_H:         bad = bad | lane[0];
            F3_HU:        bad = bad | wr | lane[0];
            F3_W:         bad = bad | (lane != 2'b00);
            default:      bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM with per-byte write enables and a registered read.
module dmem_array #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store responder: request capture, error checks, wait states.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WrData,
    output logic [31:0]       RdData,
    output logic              Stall,
    output logic              Done,
    output logic              Err
);

    localparam int         WW        = ADDR_W - 2;
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

    state_e              state_q;
    logic [3:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          f3_q;
    logic [31:0]         wdata_q;
    logic                wr_q;
    logic                err_q;

    logic                req;
    logic                bad;
    logic                live;
    logic                commit;
    logic [WW-1:0]       a_word;
    logic [1:0]          a_lane;
    logic [2:0]          a_f3;
    logic [31:0]         a_wd;
    logic                a_wr;
    logic [3:0]          ram_be;
    logic [31:0]         ram_rd;

    assign req  = MemRead | MemWrite;
    assign bad  = req_err(MemRead, MemWrite, Funct3, Addr[1:0]);
    assign live = (state_q == IDLE);

    // With no wait states the access happens on the accepting edge,
    // so the RAM is driven from the live request while idle.
    assign a_word = live ? Addr[ADDR_W-1:2] : addr_q[ADDR_W-1:2];
    assign a_lane = live ? Addr[1:0]        : addr_q[1:0];
    assign a_f3   = live ? Funct3           : f3_q;
    assign a_wd   = live ? WrData           : wdata_q;
    assign a_wr   = live ? MemWrite         : wr_q;

    assign commit = (state_q == WAIT && cnt_q == 4'd0 && !err_q)
                  | (NO_WAIT && live && req && !bad);

    assign ram_be = (commit && a_wr) ? byte_en(a_f3, a_lane) : 4'b0000;

    dmem_array #(
        .AW(WW)
    ) u_array (
        .clk    (clk),
        .be_i   (ram_be),
        .addr_i (a_word),
        .wdata_i(store_align(a_f3, a_wd)),
        .rdata_o(ram_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            f3_q    <= 3'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= Addr;
                        f3_q    <= Funct3;
                        wdata_q <= WrData;
                        wr_q    <= MemWrite;
                        err_q   <= bad;
                        if (bad || NO_WAIT) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The RAM output register is loaded on the edge entering RESP.
    assign Done   = (state_q == RESP);
    assign Err    = Done & err_q;
    assign RdData = (Done && !err_q && !wr_q)
                  ? load_ext(ram_rd, f3_q, addr_q[1:0]) : 32'd0;
    assign Stall  = !reset & ((live & req) | (state_q == WAIT));

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl at WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        rd, wr, z_rd, z_wr;
    logic [2:0]  f3, z_f3;
    logic [8:0]  addr, z_addr;
    logic [31:0] wdata, z_wdata;
    logic [31:0] rdata, z_rdata;
    logic        stall, done, err, z_stall, z_done, z_err;

    dmem_ctrl #(.ADDR_W(9), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset),
        .MemRead(rd), .MemWrite(wr), .Funct3(f3),
        .Addr(addr), .WrData(wdata),
        .RdData(rdata), .Stall(stall), .Done(done), .Err(err)
    );

    dmem_ctrl #(.ADDR_W(9), .WAIT_CYCLES(0)) u_z (
        .clk(clk), .reset(reset),
        .MemRead(z_rd), .MemWrite(z_wr), .Funct3(z_f3),
        .Addr(z_addr), .WrData(z_wdata),
        .RdData(z_rdata), .Stall(z_stall), .Done(z_done), .Err(z_err)
    );

    bit sel;
    wire        o_stall = sel ? z_stall : stall;
    wire        o_done  = sel ? z_done  : done;
    wire        o_err   = sel ? z_err   : err;
    wire [31:0] o_rdata = sel ? z_rdata : rdata;

    typedef struct {
        bit          z;
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [8:0]  a;
        logic [31:0] wd;
        bit          scr;
        int          stall;
        bit          err;
        logic [31:0] rdat;
        string       name;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic vec_t mk(
        bit z, bit r, bit w, logic [2:0] f, logic [8:0] a,
        logic [31:0] wd, bit scr, int st, bit e, logic [31:0] rv,
        string n
    );
        vec_t v;
        v.z = z; v.rd = r; v.wr = w; v.f3 = f; v.a = a;
        v.wd = wd; v.scr = scr; v.stall = st; v.err = e;
        v.rdat = rv; v.name = n;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rd = 0; wr = 0; f3 = 0; addr = 0; wdata = 0;
        z_rd = 0; z_wr = 0; z_f3 = 0; z_addr = 0; z_wdata = 0;
    endtask

    task automatic run(vec_t v);
        int nst;
        int lat;
        bit got;
        nst = 0; lat = 0; got = 0;
        @(negedge clk);
        sel = v.z;
        if (v.z) begin
            z_rd = v.rd; z_wr = v.wr; z_f3 = v.f3;
            z_addr = v.a; z_wdata = v.wd;
        end else begin
            rd = v.rd; wr = v.wr; f3 = v.f3;
            addr = v.a; wdata = v.wd;
        end
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (o_done) begin
                lat = c;
                got = 1;
                break;
            end
            if (o_stall) nst++;
            @(negedge clk);
            if (v.scr && c == 1) begin
                addr  = addr ^ 9'h004;
                wdata = ~wdata;
            end
        end
        chk({v.name, " done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({v.name, " latency"}, 32'(lat - 1), 32'(v.stall));
            chk({v.name, " stall_cycles"}, 32'(nst), 32'(v.stall));
            chk({v.name, " stall_at_done"}, 32'(o_stall), 32'd0);
            chk({v.name, " err"}, 32'(o_err), 32'(v.err));
            chk({v.name, " rdata"}, o_rdata, v.rdat);
        end
        idle_inputs();
        @(negedge clk);
        #1;
        chk({v.name, " done_pulse"}, 32'(o_done), 32'd0);
    endtask

    initial begin
        idle_inputs();
        sel   = 0;
        reset = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset rdata", rdata, 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        reset = 0;

        tv.push_back(mk(0,0,1,F3_W, 9'h010,32'hDEADBEEF,0,3,0,32'h0,"sw10"));
        tv.push_back(mk(0,1,0,F3_W, 9'h010,32'h0,0,3,0,32'hDEADBEEF,"lw10"));
        tv.push_back(mk(0,0,1,F3_B, 9'h013,32'h12345680,0,3,0,32'h0,"sb13"));
        tv.push_back(mk(0,1,0,F3_B, 9'h013,32'h0,0,3,0,32'hFFFFFF80,"lb13"));
        tv.push_back(mk(0,1,0,F3_BU,9'h013,32'h0,0,3,0,32'h00000080,"lbu13"));
        tv.push_back(mk(0,1,0,F3_W, 9'h010,32'h0,0,3,0,32'h80ADBEEF,"lw10b"));
        tv.push_back(mk(0,0,1,F3_H, 9'h012,32'hABCD8001,0,3,0,32'h0,"sh12"));
        tv.push_back(mk(0,1,0,F3_H, 9'h012,32'h0,0,3,0,32'hFFFF8001,"lh12"));
        tv.push_back(mk(0,1,0,F3_HU,9'h012,32'h0,0,3,0,32'h00008001,"lhu12"));
        tv.push_back(mk(0,1,0,F3_W, 9'h011,32'h0,0,1,1,32'h0,"lw11_mis"));
        tv.push_back(mk(0,0,1,F3_H, 9'h013,32'hFFFFFFFF,0,1,1,32'h0,"sh13_mis"));
        tv.push_back(mk(0,1,0,F3_W, 9'h010,32'h0,0,3,0,32'h8001BEEF,"lw10c"));
        tv.push_back(mk(0,1,0,F3_H, 9'h010,32'h0,0,3,0,32'hFFFFBEEF,"lh10"));
        tv.push_back(mk(0,1,0,F3_BU,9'h011,32'h0,0,3,0,32'h000000BE,"lbu11"));
        tv.push_back(mk(0,1,0,F3_B, 9'h010,32'h0,0,3,0,32'hFFFFFFEF,"lb10"));
        tv.push_back(mk(0,0,1,F3_B, 9'h014,32'h0000007F,0,3,0,32'h0,"sb14"));
        tv.push_back(mk(0,1,0,F3_B, 9'h014,32'h0,0,3,0,32'h0000007F,"lb14"));
        tv.push_back(mk(0,0,1,F3_W, 9'h018,32'hCAFEF00D,1,3,0,32'h0,"sw18_scr"));
        tv.push_back(mk(0,1,0,F3_W, 9'h018,32'h0,0,3,0,32'hCAFEF00D,"lw18"));
        tv.push_back(mk(0,1,1,F3_W, 9'h010,32'h0,0,1,1,32'h0,"rdwr"));
        tv.push_back(mk(0,1,0,3'b011,9'h010,32'h0,0,1,1,32'h0,"ld_f3_011"));
        tv.push_back(mk(0,1,0,3'b110,9'h010,32'h0,0,1,1,32'h0,"ld_f3_110"));
        tv.push_back(mk(0,0,1,F3_BU,9'h010,32'h0,0,1,1,32'h0,"st_f3_100"));
        tv.push_back(mk(0,1,0,F3_W, 9'h010,32'h0,0,3,0,32'h8001BEEF,"lw10d"));
        tv.push_back(mk(0,0,1,F3_W, 9'h020,32'h11223344,0,3,0,32'h0,"sw20"));
        tv.push_back(mk(1,0,1,F3_W, 9'h040,32'h0BADF00D,0,1,0,32'h0,"z_sw40"));
        tv.push_back(mk(1,1,0,F3_W, 9'h040,32'h0,0,1,0,32'h0BADF00D,"z_lw40"));
        tv.push_back(mk(1,1,0,F3_B, 9'h041,32'h0,0,1,0,32'hFFFFFFF0,"z_lb41"));
        tv.push_back(mk(1,1,0,F3_W, 9'h042,32'h0,0,1,1,32'h0,"z_lw42_mis"));
        tv.push_back(mk(1,1,1,F3_W, 9'h040,32'h0,0,1,1,32'h0,"z_rdwr"));

        foreach (tv[i]) run(tv[i]);

        // Store dropped by a reset arriving during its wait states.
        sel = 0;
        @(negedge clk);
        wr = 1; f3 = F3_W; addr = 9'h020; wdata = 32'h55667788;
        @(negedge clk);
        #1;
        chk("mid stall_in_wait", 32'(stall), 32'd1);
        reset = 1;
        #1;
        chk("mid reset stall", 32'(stall), 32'd0);
        chk("mid reset done", 32'(done), 32'd0);
        chk("mid reset err", 32'(err), 32'd0);
        chk("mid reset rdata", rdata, 32'd0);
        @(negedge clk);
        idle_inputs();
        reset = 0;
        #1;
        chk("after reset stall", 32'(stall), 32'd0);
        run(mk(0,1,0,F3_W,9'h020,32'h0,0,3,0,32'h11223344,"lw20_old"));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
